// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan_gen: frame content/controls in, digit and segment drive out.
// en is a level enable, not a handshake; content is sampled by the scanner only at frame start.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   blink;
  logic                    hex_mode;
  logic [NUM_DIGITS-1:0]   wei;
  logic [7:0]              duan;
  logic                    frame_done;

  modport master (
    output en, digits, dp, blank, blink, hex_mode,
    input  wei, duan, frame_done
  );

  modport slave (
    input  en, digits, dp, blank, blink, hex_mode,
    output wei, duan, frame_done
  );
endinterface

// File: rtl/seg_scan_gen.sv
// Multiplexed 7-segment scanner: one blanking GAP cycle then DWELL lit cycles per digit,
// with a per-frame snapshot of the display content and a free-running blink counter.
module seg_scan_gen #(
  parameter int NUM_DIGITS     = 8,
  parameter int DWELL          = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLINK_W        = 16
) (
  input  logic       clk_xHZ,
  input  logic       rst_n,
  seg_scan_if.slave  bus,
  output logic [1:0] fsm_state
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DW_W-1:0]       DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [NUM_DIGITS-1:0] WEI_OFF    = {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};
  localparam logic [7:0]            DUAN_OFF   = {8{SEG_ACTIVE_LOW != 0}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GAP  = 2'd1;
  localparam logic [1:0] SHOW = 2'd2;

  logic [1:0]              state, state_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [DW_W-1:0]         dwell, dwell_n;
  logic                    take_snap;
  logic [BLINK_W-1:0]      blink_cnt;

  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_blank, snap_blink;
  logic                    snap_hex;

  logic [3:0]              nib;
  logic                    nib_dp, nib_blank, nib_blink;
  logic                    dark;
  logic [7:0]              seg_hi;
  logic [NUM_DIGITS-1:0]   sel_hi;
  logic [NUM_DIGITS-1:0]   wei_n;
  logic [7:0]              duan_n;
  logic                    fd_n;

  assign fsm_state = state;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = 7'h77;
      4'hB:    glyph = 7'h7C;
      4'hC:    glyph = 7'h39;
      4'hD:    glyph = 7'h5E;
      4'hE:    glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  // Dropping en wins over every state so the display blanks on the very next edge.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    dwell_n   = dwell;
    take_snap = 1'b0;
    if (!bus.en) begin
      state_n = IDLE;
      idx_n   = '0;
      dwell_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n   = GAP;
          idx_n     = '0;
          dwell_n   = '0;
          take_snap = 1'b1;
        end
        GAP: begin
          state_n = SHOW;
          dwell_n = '0;
        end
        SHOW: begin
          if (dwell == DWELL_LAST) begin
            state_n = GAP;
            dwell_n = '0;
            if (idx == IDX_LAST) begin
              idx_n     = '0;
              take_snap = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            dwell_n = dwell + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          dwell_n = '0;
        end
      endcase
    end
  end

  // Outputs are computed for the state being entered, so they register alongside it.
  always_comb begin
    nib       = 4'h0;
    nib_dp    = 1'b0;
    nib_blank = 1'b0;
    nib_blink = 1'b0;
    sel_hi    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_n == IDX_W'(i)) begin
        nib       = snap_digits[4*i +: 4];
        nib_dp    = snap_dp[i];
        nib_blank = snap_blank[i];
        nib_blink = snap_blink[i];
        sel_hi[i] = 1'b1;
      end
    end
    dark   = nib_blank || ((nib > 4'd9) && !snap_hex) || (nib_blink && blink_cnt[BLINK_W-1]);
    seg_hi = dark ? 8'h00 : {nib_dp, glyph(nib)};
    if (state_n == SHOW) begin
      wei_n  = sel_hi ^ WEI_OFF;
      duan_n = seg_hi ^ DUAN_OFF;
      fd_n   = (idx_n == IDX_LAST) && (dwell_n == DWELL_LAST);
    end else begin
      wei_n  = WEI_OFF;
      duan_n = DUAN_OFF;
      fd_n   = 1'b0;
    end
  end

  always_ff @(posedge clk_xHZ or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      dwell     <= '0;
      blink_cnt <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      dwell     <= dwell_n;
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_xHZ or negedge rst_n) begin
    if (!rst_n) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
      snap_blink  <= '0;
      snap_hex    <= 1'b0;
    end else if (take_snap) begin
      snap_digits <= bus.digits;
      snap_dp     <= bus.dp;
      snap_blank  <= bus.blank;
      snap_blink  <= bus.blink;
      snap_hex    <= bus.hex_mode;
    end
  end

  always_ff @(posedge clk_xHZ or negedge rst_n) begin
    if (!rst_n) begin
      bus.wei        <= WEI_OFF;
      bus.duan       <= DUAN_OFF;
      bus.frame_done <= 1'b0;
    end else begin
      bus.wei        <= wei_n;
      bus.duan       <= duan_n;
      bus.frame_done <= fd_n;
    end
  end

endmodule
